mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 36 +++
 rtl/mem_responder_ram.sv | 42 ++++
 rtl/mem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared size encodings, FSM state type, default parameters and lane helpers for mem_responder.
// The optional misalignment check is enabled with the MEM_RESPONDER_MISALIGN_EN macro.
package mem_responder_pkg;

    localparam int unsigned WAIT_CYCLES_DEF = 1;
    localparam int unsigned DEPTH_BYTES_DEF = 256;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    // Lane 0 is the byte at the base address (most significant in big-endian order).
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_HALF: return 4'b0011;
            SZ_BYTE: return 4'b0001;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_HALF: return lsb[0];
            SZ_BYTE: return 1'b0;
            default: return lsb != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Byte-addressed storage with four byte-lane write enables and a 4-byte combinational
// big-endian read starting at base_i; lane addresses wrap modulo DEPTH_BYTES.
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF
) (
    input  logic        clk_i,
    input  logic [31:0] base_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic [AW-1:0] idx   [4];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            idx[i] = AW'((base_i + 32'(i)) % 32'(DEPTH_BYTES));
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rdata_o[31 - 8*i -: 8] = mem_q[idx[i]];
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[idx[i]] <= wdata_i[31 - 8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: latches a request, stalls WAIT_CYCLES, performs one access,
// then pulses ready. Define MEM_RESPONDER_MISALIGN_EN to trap misaligned word/half accesses.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        fault
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        busy_q;
    logic        fault_q;

    logic [31:0] base;
    logic [31:0] ram_rdata;
    logic [31:0] wr_lanes;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic        misalign;

`ifdef MEM_RESPONDER_MISALIGN_EN
    assign misalign = is_misaligned(size_q, addr_q[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign base = addr_q % 32'(DEPTH_BYTES);

    // Sub-word stores are shifted into the top lanes; sub-word loads come back zero-extended.
    always_comb begin
        wr_lanes  = wdata_q;
        load_data = ram_rdata;
        case (size_q)
            SZ_HALF: begin
                wr_lanes  = {wdata_q[15:0], 16'h0000};
                load_data = {16'h0000, ram_rdata[31:16]};
            end
            SZ_BYTE: begin
                wr_lanes  = {wdata_q[7:0], 24'h000000};
                load_data = {24'h000000, ram_rdata[31:24]};
            end
            default: ;
        endcase
    end

    assign be = (state_q == S_ACCESS && we_q && !misalign) ? lane_mask(size_q) : '0;

    mem_responder_ram #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_ram (
        .clk_i  (clock),
        .base_i (base),
        .be_i   (be),
        .wdata_i(wr_lanes),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= WAIT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q   <= '0;
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    fault_q <= misalign;
                    if (!we_q && !misalign) begin
                        rdata_q <= load_data;
                    end
                    state_q <= S_RESP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule
